fetch_unit: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. Drives PC to instruction memory

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, one-cycle ack with read data back.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Fetches one word per cycle at most over a req/ack bus, redirects on taken
// jumps/branches, and supports decode stalls.
// Build option: DELAY_SLOT_EN keeps the word fetched behind a taken redirect
// (MIPS delay slot); without it that word is squashed.
//
// state   | meaning
// IDLE    | first cycle out of reset, no request
// FETCH   | request asserted at pc
// HOLD    | word fetched during a stall, parked until decode accepts it
// DISCARD | stale fetch still in flight after a redirect (squash build only)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic [1:0]   jump,
    input  logic [1:0]   branch,
    input  logic         zero,
    input  logic [31:0]  jr_target,
    output logic [31:0]  if_id_instr,
    output logic [31:0]  if_id_pc4,
    output logic         if_id_valid,
    output logic [5:0]   opcode
);

`ifdef DELAY_SLOT_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
`endif

    state_t      state, state_d;
    logic [31:0] pc, pc_d, pc_plus4;
    logic [31:0] hold_word, hold_d;
    logic [31:0] pend_target, pend_target_d;
    logic        pend_valid, pend_valid_d;
    logic [31:0] instr_d, pc4_d;
    logic        valid_d;
    logic        jump_hit, branch_hit, taken;
    logic [31:0] target;
`ifdef DELAY_SLOT_EN
    logic [31:0] pc_after_word;
`endif

    assign pc_plus4  = pc + 32'd4;
    assign imem.addr = pc;
    assign opcode    = if_id_instr[31:26];

    // Redirect decision and target for the instruction sitting in IF/ID; jump beats branch.
    always_comb begin
        jump_hit   = (jump == 2'b01) || (jump == 2'b10);
        branch_hit = ((branch == 2'b10) && zero) || ((branch == 2'b11) && !zero);
        taken      = if_id_valid && !stall && (jump_hit || branch_hit);
        if (jump == 2'b01)
            target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
        else if (jump == 2'b10)
            target = jr_target;
        else
            target = if_id_pc4 + {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
    end

`ifdef DELAY_SLOT_EN
    // Address following a word loaded into IF/ID: a fresh or latched redirect overrides pc+4.
    always_comb begin
        if (taken)
            pc_after_word = target;
        else if (pend_valid)
            pc_after_word = pend_target;
        else
            pc_after_word = pc_plus4;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
`ifdef DELAY_SLOT_EN
                if (imem.ack && stall)
                    state_d = HOLD;
`else
                if (imem.ack && stall)
                    state_d = HOLD;
                else if (!imem.ack && taken)
                    state_d = DISCARD;
`endif
            end
            HOLD: begin
                if (!stall)
                    state_d = FETCH;
            end
`ifdef DELAY_SLOT_EN
            default: state_d = IDLE;
`else
            DISCARD: begin
                if (imem.ack)
                    state_d = FETCH;
            end
            default: state_d = IDLE;
`endif
        endcase
    end

    // Request output and next values for pc, IF/ID, hold word and pending redirect.
    // IF/ID advances every unstalled cycle, so it becomes a bubble unless a word is loaded.
    always_comb begin
        imem.req      = 1'b0;
        pc_d          = pc;
        instr_d       = if_id_instr;
        pc4_d         = if_id_pc4;
        valid_d       = if_id_valid;
        hold_d        = hold_word;
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        if (!stall) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
        end
        case (state)
            FETCH: begin
                imem.req = 1'b1;
`ifdef DELAY_SLOT_EN
                if (imem.ack) begin
                    if (stall) begin
                        hold_d = imem.rdata;
                    end else begin
                        instr_d      = imem.rdata;
                        pc4_d        = pc_plus4;
                        valid_d      = 1'b1;
                        pc_d         = pc_after_word;
                        pend_valid_d = 1'b0;
                    end
                end else if (taken) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = target;
                end
`else
                if (imem.ack) begin
                    if (taken) begin
                        pc_d = target;
                    end else if (stall) begin
                        hold_d = imem.rdata;
                    end else begin
                        instr_d = imem.rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (taken) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = target;
                end
`endif
            end
            HOLD: begin
                if (!stall) begin
`ifdef DELAY_SLOT_EN
                    instr_d      = hold_word;
                    pc4_d        = pc_plus4;
                    valid_d      = 1'b1;
                    pc_d         = pc_after_word;
                    pend_valid_d = 1'b0;
`else
                    if (taken) begin
                        pc_d = target;
                    end else begin
                        instr_d = hold_word;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
`endif
                end
            end
`ifdef DELAY_SLOT_EN
            default: ;
`else
            DISCARD: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    pc_d         = pend_target;
                    pend_valid_d = 1'b0;
                end
            end
            default: ;
`endif
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            hold_word   <= 32'h0;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            pc          <= pc_d;
            if_id_instr <= instr_d;
            if_id_pc4   <= pc4_d;
            if_id_valid <= valid_d;
            hold_word   <= hold_d;
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a redirect vector
// table, and a randomized run against a program-order reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, zero;
    logic [1:0]  jump, branch;
    logic [31:0] jr_target;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem(imem), .stall(stall), .jump(jump),
        .branch(branch), .zero(zero), .jr_target(jr_target),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .opcode(opcode)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  jump;
        logic [1:0]  branch;
        logic        zero;
        logic [31:0] jr_tgt;
        logic        taken;
        logic [31:0] target;
    } vec_t;
    vec_t vecs[14];

    // random-phase model state
    logic [31:0] exp_addr, prev_addr, cur_jr, ins;
    logic [1:0]  cur_j, cur_b;
    logic        cur_z, prev_stall, prev_req, prev_ack, tk;
    logic [31:0] tgt;
    int          delivered, loads, k;
`ifdef DELAY_SLOT_EN
    logic        ds_pend;
    logic [31:0] ds_tgt;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] br_tgt(input logic [31:0] pc4, input logic [31:0] instr);
        int off;
        off = $signed(instr[15:0]);
        return pc4 + 32'(off * 4);
    endfunction

    function automatic logic [31:0] j_tgt(input logic [31:0] pc4, input logic [31:0] instr);
        return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
    endfunction

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; jump = 2'b00; branch = 2'b00; zero = 1'b0;
        jr_target = 32'h0; imem.ack = 1'b0; imem.rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0]  = '{32'h0000_00FC, 32'h1022_FFFF, 2'b00, 2'b10, 1'b1, 32'h0,         1'b1, 32'h0000_00FC};
        vecs[1]  = '{32'h0000_00FC, 32'h1022_FFFF, 2'b00, 2'b10, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2]  = '{32'h0000_0200, 32'h1422_0010, 2'b00, 2'b11, 1'b0, 32'h0,         1'b1, 32'h0000_0244};
        vecs[3]  = '{32'h0000_0200, 32'h1422_0010, 2'b00, 2'b11, 1'b1, 32'h0,         1'b0, 32'h0};
        vecs[4]  = '{32'h0000_0010, 32'h0800_0010, 2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 32'h0000_0040};
        vecs[5]  = '{32'h3000_0000, 32'h0800_0010, 2'b01, 2'b00, 1'b0, 32'h0,         1'b1, 32'h3000_0040};
        vecs[6]  = '{32'h0000_0500, 32'h03E0_0008, 2'b10, 2'b00, 1'b0, 32'h0000_2000, 1'b1, 32'h0000_2000};
        vecs[7]  = '{32'h0000_0080, 32'h1000_0004, 2'b11, 2'b10, 1'b1, 32'h0,         1'b1, 32'h0000_0094};
        vecs[8]  = '{32'h0000_0080, 32'h1000_0004, 2'b11, 2'b00, 1'b1, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{32'h0000_0080, 32'h1000_0004, 2'b00, 2'b01, 1'b1, 32'h0,         1'b0, 32'h0};
        vecs[10] = '{32'h0000_0010, 32'h0800_0010, 2'b01, 2'b10, 1'b1, 32'h0,         1'b1, 32'h0000_0040};
        vecs[11] = '{32'hFFFF_FFF0, 32'h1000_0008, 2'b00, 2'b10, 1'b1, 32'h0,         1'b1, 32'h0000_0014};
        vecs[12] = '{32'h0004_0000, 32'h1000_8000, 2'b00, 2'b10, 1'b1, 32'h0,         1'b1, 32'h0002_0004};
        vecs[13] = '{32'h0000_0500, 32'h1422_0010, 2'b10, 2'b11, 1'b0, 32'h1234_5670, 1'b1, 32'h1234_5670};

        // ---- reset values and first request
        reset = 1'b1; stall = 1'b0; jump = 2'b00; branch = 2'b00; zero = 1'b0;
        jr_target = 32'h0; imem.ack = 1'b1; imem.rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rst_req", {31'h0, imem.req}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_opcode", {26'h0, opcode}, 32'h0);
        reset = 1'b0;
        imem.ack = 1'b0;
        chk("idle_req", {31'h0, imem.req}, 32'h0);
        tick();

        // ---- ack every cycle from address 0
        for (int i = 0; i < 6; i++) begin
            chk("seq_req", {31'h0, imem.req}, 32'h1);
            chk("seq_addr", imem.addr, 32'(i * 4));
            imem.ack = 1'b1;
            imem.rdata = mem_word(32'(i * 4));
            tick();
            chk("seq_valid", {31'h0, if_id_valid}, 32'h1);
            chk("seq_instr", if_id_instr, mem_word(32'(i * 4)));
            chk("seq_pc4", if_id_pc4, 32'(i * 4 + 4));
            chk("seq_opcode", {26'h0, opcode}, {26'h0, mem_word(32'(i * 4)) >> 26});
        end

        // ---- ack delayed 3 cycles at 0x18
        loads = 0;
        imem.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'h0, imem.req}, 32'h1);
            chk("wait_addr", imem.addr, 32'h18);
            if (if_id_valid) loads++;
        end
        imem.ack = 1'b1;
        imem.rdata = mem_word(32'h18);
        tick();
        if (if_id_valid) loads++;
        chk("wait_instr", if_id_instr, mem_word(32'h18));
        imem.ack = 1'b0;
        tick();
        if (if_id_valid) loads++;
        chk("wait_one_load", 32'(loads), 32'd1);

        // ---- stall at ack for 4 cycles
        imem.ack = 1'b1;
        imem.rdata = mem_word(32'h1C);
        tick();
        stall = 1'b1;
        imem.rdata = mem_word(32'h20);
        tick();
        imem.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", {31'h0, imem.req}, 32'h0);
            chk("hold_ifid", if_id_instr, mem_word(32'h1C));
            tick();
        end
        chk("hold_ifid_last", if_id_instr, mem_word(32'h1C));
        stall = 1'b0;
        tick();
        chk("hold_release_instr", if_id_instr, mem_word(32'h20));
        chk("hold_release_pc4", if_id_pc4, 32'h24);
        chk("hold_release_valid", {31'h0, if_id_valid}, 32'h1);
        chk("hold_release_addr", imem.addr, 32'h24);

        // ---- jr 0x2000 with fetch outstanding
        jump = 2'b10;
        jr_target = 32'h2000;
        imem.ack = 1'b0;
        tick();
        jump = 2'b00;
        chk("jr_bubble", {31'h0, if_id_valid}, 32'h0);
        chk("jr_req", {31'h0, imem.req}, 32'h1);
        chk("jr_stale_addr", imem.addr, 32'h24);
        imem.ack = 1'b1;
        imem.rdata = mem_word(32'h24);
        tick();
`ifdef DELAY_SLOT_EN
        chk("jr_slot_valid", {31'h0, if_id_valid}, 32'h1);
        chk("jr_slot_instr", if_id_instr, mem_word(32'h24));
`else
        chk("jr_drop_valid", {31'h0, if_id_valid}, 32'h0);
`endif
        chk("jr_target_addr", imem.addr, 32'h2000);
        imem.rdata = mem_word(32'h2000);
        tick();
        chk("jr_new_instr", if_id_instr, mem_word(32'h2000));
        chk("jr_new_pc4", if_id_pc4, 32'h2004);

        // ---- reset mid-transaction, ack during reset and IDLE ignored
        reset = 1'b1;
        imem.ack = 1'b1;
        tick();
        chk("mid_rst_req", {31'h0, imem.req}, 32'h0);
        chk("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_req", {31'h0, imem.req}, 32'h1);
        chk("post_rst_addr", imem.addr, 32'h0);
        chk("post_rst_valid", {31'h0, if_id_valid}, 32'h0);
        imem.ack = 1'b0;

        // ---- redirect vector table
        for (int i = 0; i < 14; i++) begin
            do_reset();
            imem.ack = 1'b1;
            imem.rdata = 32'h0;
            tick();
            jump = 2'b10;
            jr_target = vecs[i].pc;
            tick();
            jump = 2'b00;
            chk($sformatf("vec%0d_addr", i), imem.addr, vecs[i].pc);
            imem.rdata = vecs[i].instr;
            tick();
            chk($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].instr);
            chk($sformatf("vec%0d_pc4", i), if_id_pc4, vecs[i].pc + 32'd4);
            jump = vecs[i].jump;
            branch = vecs[i].branch;
            zero = vecs[i].zero;
            jr_target = vecs[i].jr_tgt;
            imem.rdata = 32'h0;
            tick();
`ifdef DELAY_SLOT_EN
            chk($sformatf("vec%0d_valid", i), {31'h0, if_id_valid}, 32'h1);
`else
            chk($sformatf("vec%0d_valid", i), {31'h0, if_id_valid}, {31'h0, !vecs[i].taken});
`endif
            chk($sformatf("vec%0d_next", i), imem.addr,
                vecs[i].taken ? vecs[i].target : vecs[i].pc + 32'd8);
            jump = 2'b00; branch = 2'b00; zero = 1'b0; imem.ack = 1'b0;
        end

        // ---- randomized run against program-order model
        do_reset();
        exp_addr = 32'h0; prev_stall = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        prev_addr = 32'h0; delivered = 0;
        cur_j = 2'b00; cur_b = 2'b00; cur_z = 1'b0; cur_jr = 32'h0;
`ifdef DELAY_SLOT_EN
        ds_pend = 1'b0; ds_tgt = 32'h0;
`endif
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_req && !prev_ack) begin
                chk("rnd_req_hold", {31'h0, imem.req}, 32'h1);
                chk("rnd_addr_hold", imem.addr, prev_addr);
            end
            if (if_id_valid && !prev_stall) begin
                delivered++;
                ins = mem_word(exp_addr);
                chk("rnd_instr", if_id_instr, ins);
                chk("rnd_pc4", if_id_pc4, exp_addr + 32'd4);
                cur_j = 2'b00; cur_b = 2'b00;
                cur_z = 1'($urandom_range(1));
                cur_jr = $urandom & 32'hFFFF_FFFC;
                tk = 1'b0; tgt = 32'h0;
                k = int'($urandom_range(7));
                case (k)
                    0: begin cur_j = 2'b01; tk = 1'b1; tgt = j_tgt(exp_addr + 32'd4, ins); end
                    1: begin cur_j = 2'b10; tk = 1'b1; tgt = cur_jr; end
                    2: begin cur_b = 2'b10; tk = cur_z; tgt = br_tgt(exp_addr + 32'd4, ins); end
                    3: begin cur_b = 2'b11; tk = !cur_z; tgt = br_tgt(exp_addr + 32'd4, ins); end
                    4: begin cur_j = 2'b11; cur_b = {1'b0, cur_z}; end
                    5: begin cur_j = 2'b01; cur_b = 2'b10; tk = 1'b1; tgt = j_tgt(exp_addr + 32'd4, ins); end
                    default: cur_b = {1'b0, cur_z};
                endcase
`ifdef DELAY_SLOT_EN
                if (ds_pend) begin
                    cur_j = 2'b00; cur_b = 2'b00;
                    exp_addr = ds_tgt;
                    ds_pend = 1'b0;
                end else if (tk) begin
                    ds_pend = 1'b1;
                    ds_tgt = tgt;
                    exp_addr = exp_addr + 32'd4;
                end else begin
                    exp_addr = exp_addr + 32'd4;
                end
`else
                exp_addr = tk ? tgt : exp_addr + 32'd4;
`endif
            end else if (!if_id_valid) begin
                cur_j = 2'b00; cur_b = 2'b00;
            end
            stall = ($urandom_range(3) == 0);
            imem.ack = imem.req && ($urandom_range(2) != 0);
            imem.rdata = mem_word(imem.addr);
            jump = cur_j; branch = cur_b; zero = cur_z; jr_target = cur_jr;
            prev_stall = stall; prev_req = imem.req; prev_ack = imem.ack; prev_addr = imem.addr;
            tick();
        end
        chk("rnd_progress", {31'h0, delivered >= 200}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
